spi_slave_param: RTL and testbench

//  Parametrised SPI slave front-end for the SPI-RAM subsystem, sitting between the SPI pins and the RAM's rx/tx bus.

---
 rtl/spi_ram_pkg.sv | 39 +++
 rtl/spi_tx_serialiser.sv | 99 +++++++++
 rtl/spi_slave_param.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and command encodings for the SPI-RAM slave front-end.
package spi_ram_pkg;

    // Top-level transaction state.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    // Sub-phase inside WRITE/READ_ADD/READ_DATA.
    typedef enum logic [1:0] {
        PH_RX   = 2'd0,   // shifting frame bits in
        PH_WAIT = 2'd1,   // READ_DATA: waiting for tx_valid
        PH_TX   = 2'd2,   // READ_DATA: serialiser driving MISO
        PH_HOLD = 2'd3    // frame finished, ignoring MOSI until SS_n rises
    } phase_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Whether a received command pair is acceptable for the state it arrived in.
    function automatic logic cmd_legal(input state_e st, input logic [1:0] cmd);
        logic ok;
        ok = 1'b0;
        case (st)
            WRITE:     ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  ok = (cmd == CMD_RD_ADDR);
            READ_DATA: ok = (cmd == CMD_RD_DATA);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/spi_tx_serialiser.sv
// Loads one RAM read word and drives it onto MISO, one bit per clock.
// MISO shows the first bit in the cycle after load_i; last_o marks the
// cycle in which the final (DATA_W-th) bit is on MISO.
module spi_tx_serialiser #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              last_o
);
    import spi_ram_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              miso_q,  miso_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              busy_q,  busy_d;

    // Bit that leaves the word first, depending on shift order.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        logic b;
        if (LSB_FIRST != 0) begin
            b = w[0];
        end else begin
            b = w[DATA_W-1];
        end
        return b;
    endfunction

    // Word with the outgoing bit removed, next bit moved into the exit position.
    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        if (LSB_FIRST != 0) begin
            r = {1'b0, w[DATA_W-1:1]};
        end else begin
            r = {w[DATA_W-2:0], 1'b0};
        end
        return r;
    endfunction

    assign last_o = busy_q && (cnt_q == CNT_LAST);
    assign miso_o = miso_q;

    // Next-state logic: clear beats load, load beats shifting.
    always_comb begin
        shreg_d = shreg_q;
        miso_d  = miso_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (clear_i) begin
            shreg_d = '0;
            miso_d  = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if (load_i) begin
            miso_d  = first_bit(data_i);
            shreg_d = drop_bit(data_i);
            cnt_d   = CNT_ONE;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                miso_d  = 1'b0;
                shreg_d = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                miso_d  = first_bit(shreg_q);
                shreg_d = drop_bit(shreg_q);
                cnt_d   = cnt_q + CNT_ONE;
            end
        end else begin
            miso_d = 1'b0;
        end
    end

    // Serialiser registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            miso_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            miso_q  <= miso_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the SPI-RAM: receives
// {cmd[1:0], payload} frames on MOSI, checks the command against the
// transaction state, and returns RAM read data on MISO.
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int LSB_FIRST  = 0,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              err,
    output logic              rd_addr_hold
);
    import spi_ram_pkg::*;

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W) + 1;
    localparam int WAIT_W  = $clog2(TX_TIMEOUT) + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_TIMEOUT - 1);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WAIT_W-1:0]  wait_q,  wait_d;
    logic [FRAME_W-1:0] rx_q,    rx_d;
    logic               rx_valid_q, rx_valid_d;
    logic               err_q,      err_d;
    logic               hold_q,     hold_d;

    logic               ser_load_s;
    logic               ser_clear_s;
    logic               ser_last_s;
    logic [FRAME_W-1:0] rx_next_s;
    logic [1:0]         cmd_next_s;

    // The frame as it will look once the current MOSI bit is shifted in.
    assign rx_next_s  = {rx_q[FRAME_W-2:0], MOSI};
    assign cmd_next_s = rx_next_s[FRAME_W-1:FRAME_W-2];

    assign rx_data      = rx_q;
    assign rx_valid     = rx_valid_q;
    assign err          = err_q;
    assign rd_addr_hold = hold_q;

    spi_tx_serialiser #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .clear_i (ser_clear_s),
        .load_i  (ser_load_s),
        .data_i  (tx_data),
        .miso_o  (MISO),
        .last_o  (ser_last_s)
    );

    // Next-state and output logic; SS_n high in any active state aborts first.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        rx_d        = rx_q;
        rx_valid_d  = 1'b0;
        err_d       = 1'b0;
        hold_d      = hold_q;
        ser_load_s  = 1'b0;
        ser_clear_s = 1'b0;

        if (state_q == IDLE) begin
            phase_d = PH_RX;
            if (!SS_n) begin
                state_d = CHK_CMD;
            end else begin
                state_d = IDLE;
            end
        end else if (SS_n) begin
            // Abort: drop the partial frame silently. The address hold only
            // goes away once the final read bit has actually reached MISO.
            state_d     = IDLE;
            phase_d     = PH_RX;
            cnt_d       = '0;
            wait_d      = '0;
            rx_d        = '0;
            ser_clear_s = 1'b1;
            if (ser_last_s) begin
                hold_d = 1'b0;
            end else begin
                hold_d = hold_q;
            end
        end else begin
            case (state_q)
                CHK_CMD: begin
                    rx_d    = {{(FRAME_W-1){1'b0}}, MOSI};
                    cnt_d   = CNT_ONE;
                    phase_d = PH_RX;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (hold_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    case (phase_q)
                        PH_RX: begin
                            rx_d  = rx_next_s;
                            cnt_d = cnt_q + CNT_ONE;
                            if (cnt_q == CNT_LAST) begin
                                if (cmd_legal(state_q, cmd_next_s)) begin
                                    rx_valid_d = 1'b1;
                                    if (state_q == READ_DATA) begin
                                        phase_d = PH_WAIT;
                                        wait_d  = '0;
                                    end else if (state_q == READ_ADD) begin
                                        phase_d = PH_HOLD;
                                        hold_d  = 1'b1;
                                    end else begin
                                        phase_d = PH_HOLD;
                                    end
                                end else begin
                                    err_d   = 1'b1;
                                    phase_d = PH_HOLD;
                                end
                            end else begin
                                phase_d = PH_RX;
                            end
                        end
                        PH_WAIT: begin
                            if (tx_valid) begin
                                ser_load_s = 1'b1;
                                phase_d    = PH_TX;
                            end else if (wait_q == WAIT_LAST) begin
                                err_d   = 1'b1;
                                hold_d  = 1'b0;
                                phase_d = PH_HOLD;
                            end else begin
                                wait_d = wait_q + WAIT_ONE;
                            end
                        end
                        PH_TX: begin
                            if (ser_last_s) begin
                                hold_d  = 1'b0;
                                phase_d = PH_HOLD;
                            end else begin
                                phase_d = PH_TX;
                            end
                        end
                        PH_HOLD: begin
                            phase_d = PH_HOLD;
                        end
                        default: begin
                            phase_d = PH_HOLD;
                        end
                    endcase
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_RX;
            cnt_q      <= '0;
            wait_q     <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed self-checking bench for spi_slave_param (DATA_W=8, TX_TIMEOUT=16),
// with an MSB-first and an LSB-first instance sharing the same stimulus.
module tb_spi_slave_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic       miso_m, rx_valid_m, err_m, hold_m;
    logic [9:0] rx_data_m;
    logic       miso_l, rx_valid_l, err_l, hold_l;
    logic [9:0] rx_data_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .LSB_FIRST(0), .TX_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .MISO(miso_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m),
        .err(err_m), .rd_addr_hold(hold_m)
    );

    spi_slave_param #(.DATA_W(8), .LSB_FIRST(1), .TX_TIMEOUT(16)) u_dut_lsb (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .MISO(miso_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
        .err(err_l), .rd_addr_hold(hold_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Select, then shift a 10-bit frame MSB-first; returns in the rx_valid cycle.
    task automatic send_frame(input logic [9:0] frame);
        SS_n = 1'b0;
        step();
        for (int i = 9; i >= 0; i--) begin
            MOSI = frame[i];
            step();
        end
        MOSI = 1'b0;
    endtask

    task automatic end_txn();
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [7:0] pat;
        logic       err_seen;

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("reset_miso",     {31'd0, miso_m},     32'd0);
        check_eq("reset_rx_data",  {22'd0, rx_data_m},  32'd0);
        check_eq("reset_rx_valid", {31'd0, rx_valid_m}, 32'd0);
        check_eq("reset_err",      {31'd0, err_m},      32'd0);
        check_eq("reset_hold",     {31'd0, hold_m},     32'd0);

        // 1. write address frame
        send_frame(10'b00_1010_0101);
        check_eq("t1_rx_valid", {31'd0, rx_valid_m}, 32'd1);
        check_eq("t1_rx_data",  {22'd0, rx_data_m},  32'h0A5);
        check_eq("t1_err",      {31'd0, err_m},      32'd0);
        check_eq("t1_hold",     {31'd0, hold_m},     32'd0);
        MOSI = 1'b1;
        step();
        check_eq("t1_pulse_end", {31'd0, rx_valid_m}, 32'd0);
        check_eq("t1_rx_held",   {22'd0, rx_data_m},  32'h0A5);
        end_txn();

        // 2. read address then read data, tx_valid two cycles after rx_valid
        send_frame(10'b10_0011_1100);
        check_eq("t2_ra_rx_valid", {31'd0, rx_valid_m}, 32'd1);
        check_eq("t2_ra_rx_data",  {22'd0, rx_data_m},  32'h23C);
        check_eq("t2_ra_hold",     {31'd0, hold_m},     32'd1);
        end_txn();
        check_eq("t2_hold_kept", {31'd0, hold_m}, 32'd1);
        send_frame(10'b11_0000_0000);
        check_eq("t2_rd_rx_valid", {31'd0, rx_valid_m}, 32'd1);
        check_eq("t2_rd_rx_data",  {22'd0, rx_data_m},  32'h300);
        step();
        step();
        tx_valid = 1'b1; tx_data = 8'hC3;
        step();
        tx_valid = 1'b0; tx_data = 8'h00;
        pat = 8'b1100_0011;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t2_miso_msb_%0d", i), {31'd0, miso_m}, {31'd0, pat[7-i]});
            check_eq($sformatf("t2_miso_lsb_%0d", i), {31'd0, miso_l}, {31'd0, pat[7-i]});
            step();
        end
        check_eq("t2_miso_after", {31'd0, miso_m}, 32'd0);
        check_eq("t2_hold_clear", {31'd0, hold_m}, 32'd0);
        end_txn();

        // 3. read data with no tx_valid -> timeout
        send_frame(10'b10_0000_0001);
        check_eq("t3_ra_hold", {31'd0, hold_m}, 32'd1);
        end_txn();
        send_frame(10'b11_1111_1111);
        check_eq("t3_rx_valid", {31'd0, rx_valid_m}, 32'd1);
        check_eq("t3_rx_data",  {22'd0, rx_data_m},  32'h3FF);
        err_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (err_m) err_seen = 1'b1;
            step();
        end
        check_eq("t3_no_early_err", {31'd0, err_seen}, 32'd0);
        check_eq("t3_err",          {31'd0, err_m},    32'd1);
        check_eq("t3_hold",         {31'd0, hold_m},   32'd0);
        check_eq("t3_miso",         {31'd0, miso_m},   32'd0);
        step();
        check_eq("t3_err_pulse", {31'd0, err_m}, 32'd0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        step();
        tx_valid = 1'b0;
        step();
        check_eq("t3_late_txv_ignored", {31'd0, miso_m}, 32'd0);
        end_txn();

        // 4. abort after 5 bits, abort on the last bit, then a clean frame
        SS_n = 1'b0;
        step();
        pat = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            MOSI = pat[i];
            step();
        end
        SS_n = 1'b1; MOSI = 1'b0;
        step();
        check_eq("t4_abort_rx_valid", {31'd0, rx_valid_m}, 32'd0);
        check_eq("t4_abort_err",      {31'd0, err_m},      32'd0);
        step();
        check_eq("t4_abort_rx_valid2", {31'd0, rx_valid_m}, 32'd0);
        SS_n = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            MOSI = 1'b0;
            step();
        end
        MOSI = 1'b1; SS_n = 1'b1;
        step();
        check_eq("t4_lastbit_rx_valid", {31'd0, rx_valid_m}, 32'd0);
        check_eq("t4_lastbit_err",      {31'd0, err_m},      32'd0);
        step();
        send_frame(10'b01_1100_0011);
        check_eq("t4_rx_valid", {31'd0, rx_valid_m}, 32'd1);
        check_eq("t4_rx_data",  {22'd0, rx_data_m},  32'h1C3);
        end_txn();

        // 5. read-address command arriving while the address is held
        send_frame(10'b10_0101_0101);
        end_txn();
        check_eq("t5_hold_set", {31'd0, hold_m}, 32'd1);
        send_frame(10'b10_1111_0000);
        check_eq("t5_err",      {31'd0, err_m},      32'd1);
        check_eq("t5_rx_valid", {31'd0, rx_valid_m}, 32'd0);
        check_eq("t5_hold",     {31'd0, hold_m},     32'd1);
        step();
        check_eq("t5_err_pulse", {31'd0, err_m}, 32'd0);
        end_txn();
        check_eq("t5_hold_after", {31'd0, hold_m}, 32'd1);

        // 6a. asymmetric word to tell MSB-first from LSB-first
        send_frame(10'b11_0000_0000);
        tx_valid = 1'b1; tx_data = 8'h2D;
        step();
        tx_valid = 1'b0; tx_data = 8'h00;
        pat = 8'h2D;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t6_miso_msb_%0d", i), {31'd0, miso_m}, {31'd0, pat[7-i]});
            check_eq($sformatf("t6_miso_lsb_%0d", i), {31'd0, miso_l}, {31'd0, pat[i]});
            step();
        end
        check_eq("t6_hold_clear", {31'd0, hold_m}, 32'd0);
        end_txn();

        // 6b. reset during MISO bit 3 of a read
        send_frame(10'b10_0000_0010);
        end_txn();
        send_frame(10'b11_0000_0000);
        tx_valid = 1'b1; tx_data = 8'hC3;
        step();
        tx_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check_eq("t6_rst_miso",     {31'd0, miso_m},     32'd0);
        check_eq("t6_rst_rx_data",  {22'd0, rx_data_m},  32'd0);
        check_eq("t6_rst_rx_valid", {31'd0, rx_valid_m}, 32'd0);
        check_eq("t6_rst_err",      {31'd0, err_m},      32'd0);
        check_eq("t6_rst_hold",     {31'd0, hold_m},     32'd0);
        check_eq("t6_rst_miso_lsb", {31'd0, miso_l},     32'd0);
        rst = 1'b0;
        end_txn();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
